// File: rtl/id_ex_stage_g7.sv
// ID/EX pipeline register: captures decoded controls and operands; 1-cycle latency ID -> EX.
// Load-use hazards raise a combinational stall and inject a bubble; a flush also bubbles and wins over a stall.
module id_ex_stage_g7 #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic             id_RegWrite,
    input  logic             id_ALUSrc,
    input  logic             id_MemtoReg,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic [1:0]       id_ALUOp,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7_5,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_ALUSrc,
    output logic             ex_MemtoReg,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_Branch,
    output logic [1:0]       ex_ALUOp,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            alu_src;
        logic            memto_reg;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7_5;
    } ex_bundle_t;

    ex_bundle_t       ex_q, ex_d, id_bundle;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             uses_rs1, uses_rs2, hazard;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rd != 5'd0) &
                    ((uses_rs1 & (ex_q.rd == id_rs1)) | (uses_rs2 & (ex_q.rd == id_rs2)));
    assign stall  = hazard & ~flush;

    assign id_bundle = '{
        valid:     id_valid,
        reg_write: id_RegWrite,
        alu_src:   id_ALUSrc,
        memto_reg: id_MemtoReg,
        mem_read:  id_MemRead,
        mem_write: id_MemWrite,
        branch:    id_Branch,
        alu_op:    id_ALUOp,
        pc:        id_pc,
        rs1_data:  id_rs1_data,
        rs2_data:  id_rs2_data,
        imm:       id_imm,
        rs1:       id_rs1,
        rs2:       id_rs2,
        rd:        id_rd,
        funct3:    id_funct3,
        funct7_5:  id_funct7_5
    };

    // Bubbles are fully zeroed so downstream sees deterministic contents.
    always_comb begin
        ex_d = id_bundle;
        if (flush || hazard) begin
            ex_d = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_MemtoReg = ex_q.memto_reg;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_Branch   = ex_q.branch;
    assign ex_ALUOp    = ex_q.alu_op;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7_5 = ex_q.funct7_5;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_g7.sv
// Bench for id_ex_stage_g7: directed scenarios plus random traffic against a slot-level reference model.
module tb_id_ex_stage_g7;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, id_valid, flush;
    logic [6:0]       id_opcode;
    logic             id_RegWrite, id_ALUSrc, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]       id_ALUOp;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic             id_funct7_5;
    logic             stall, ex_valid;
    logic             ex_RegWrite, ex_ALUSrc, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]       ex_ALUOp;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7_5;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_stage_g7 #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
        .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the EX slot as a record, counters as plain integers.
    typedef struct {
        bit        valid;
        bit        rw, asrc, m2r, mrd, mwr, br;
        bit [1:0]  aluop;
        bit [31:0] pc, a, b, imm;
        bit [4:0]  rs1, rs2, rd;
        bit [2:0]  f3;
        bit        f7;
    } slot_t;

    slot_t m;
    int    m_sc, m_fc;

    function automatic bit reads(input logic [6:0] op, input int which);
        if (op inside {7'b0110011, 7'b0100011, 7'b1100011}) return 1'b1;
        if (op inside {7'b0010011, 7'b0000011}) return which == 1;
        return 1'b0;
    endfunction

    function bit model_hazard();
        if (!(m.valid && m.mrd && id_valid && m.rd != 0)) return 1'b0;
        return (reads(id_opcode, 1) && m.rd == id_rs1) || (reads(id_opcode, 2) && m.rd == id_rs2);
    endfunction

    always @(posedge clk) begin
        bit haz;
        if (reset) begin
            m = '{default: 0};
            m_sc = 0;
            m_fc = 0;
        end else begin
            haz = model_hazard();
            if (flush) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            if (haz && !flush) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (flush || haz) begin
                m = '{default: 0};
            end else begin
                m.valid = id_valid;  m.rw = id_RegWrite; m.asrc = id_ALUSrc;
                m.m2r = id_MemtoReg; m.mrd = id_MemRead; m.mwr = id_MemWrite;
                m.br = id_Branch;    m.aluop = id_ALUOp; m.pc = id_pc;
                m.a = id_rs1_data;   m.b = id_rs2_data;  m.imm = id_imm;
                m.rs1 = id_rs1;      m.rs2 = id_rs2;     m.rd = id_rd;
                m.f3 = id_funct3;    m.f7 = id_funct7_5;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, model_hazard() && !flush);
            check("ex_valid", ex_valid, m.valid);
            check("ex_ctrl", {ex_RegWrite, ex_ALUSrc, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp},
                  {m.rw, m.asrc, m.m2r, m.mrd, m.mwr, m.br, m.aluop});
            check("ex_pc", ex_pc, m.pc);
            check("ex_rs1_data", ex_rs1_data, m.a);
            check("ex_rs2_data", ex_rs2_data, m.b);
            check("ex_imm", ex_imm, m.imm);
            check("ex_idx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
            check("ex_funct", {ex_funct3, ex_funct7_5}, {m.f3, m.f7});
            check("stall_cnt", stall_cnt, m_sc);
            check("flush_cnt", flush_cnt, m_fc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decoder-like control pattern for an opcode, with random operand data.
    task automatic instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm);
        id_valid = 1'b1; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = pc; id_imm = imm;
        id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_funct3 = 3'($urandom_range(0, 7)); id_funct7_5 = 1'($urandom_range(0, 1));
        {id_RegWrite, id_ALUSrc, id_MemtoReg, id_MemRead, id_MemWrite, id_Branch, id_ALUOp} = '0;
        case (op)
            7'b0110011: begin id_RegWrite = 1; id_ALUOp = 2'b10; end
            7'b0010011: begin id_RegWrite = 1; id_ALUSrc = 1; id_ALUOp = 2'b10; end
            7'b0000011: begin id_RegWrite = 1; id_ALUSrc = 1; id_MemtoReg = 1; id_MemRead = 1; end
            7'b0100011: begin id_ALUSrc = 1; id_MemWrite = 1; end
            7'b1100011: begin id_Branch = 1; id_ALUOp = 2'b01; end
            default:    begin id_RegWrite = 1; id_ALUSrc = 1; end
        endcase
    endtask

    task automatic rand_instr();
        logic [6:0] ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
        instr(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom);
        id_valid = ($urandom_range(0, 9) != 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        rand_instr();
        // Reset with random inputs
        step();
        chk_en = 1'b1;
        rand_instr();
        step();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_stall", stall, 0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 0);

        // Normal load of an R-type
        reset = 1'b0;
        instr(7'b0110011, 5, 6, 7, 32'h100, 32'h10);
        step();
        check("ld_ex_pc", ex_pc, 32'h100);
        check("ld_ex_rd", ex_rd, 7);
        check("ld_ex_RegWrite", ex_RegWrite, 1);
        check("ld_ex_ALUOp", ex_ALUOp, 2'b10);
        check("ld_ex_valid", ex_valid, 1);
        check("ld_stall", stall, 0);

        // Load-use: lw x5 then add using x5 as rs2
        instr(7'b0000011, 1, 0, 5, 32'h104, 32'h0);
        step();
        instr(7'b0110011, 2, 5, 8, 32'h108, 32'h0);
        #1;
        check("lu_stall", stall, 1);
        step();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_mrd", ex_MemRead, 0);
        check("lu_stall_after", stall, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        step();
        check("lu_add_rd", ex_rd, 8);
        check("lu_add_valid", ex_valid, 1);
        check("lu_stall_cnt2", stall_cnt, 1);

        // No false stall: addi does not read rs2; ex_rd = x0 never hazards
        instr(7'b0000011, 1, 0, 5, 32'h10c, 32'h0);
        step();
        instr(7'b0010011, 0, 5, 9, 32'h110, 32'h1);
        #1;
        check("nf_addi_stall", stall, 0);
        instr(7'b0000011, 1, 0, 0, 32'h114, 32'h0);
        step();
        instr(7'b0110011, 0, 0, 9, 32'h118, 32'h0);
        #1;
        check("nf_x0_stall", stall, 0);

        // Flush beats hazard
        reset = 1'b1;
        step();
        reset = 1'b0;
        instr(7'b0000011, 1, 0, 5, 32'h200, 32'h0);
        step();
        instr(7'b0110011, 2, 5, 8, 32'h204, 32'h0);
        flush = 1'b1;
        #1;
        check("fp_stall", stall, 0);
        step();
        flush = 1'b0;
        check("fp_bubble", ex_valid, 0);
        check("fp_flush_cnt", flush_cnt, 1);
        check("fp_stall_cnt", stall_cnt, 0);

        // Saturation
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_instr();
            step();
        end
        check("sat_flush_cnt", flush_cnt, 15);
        flush = 1'b0;
        reset = 1'b1;
        step();
        check("sat_rst_flush_cnt", flush_cnt, 0);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rand_instr();
            step();
        end
        reset = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
